// File: rtl/itof_pipe.sv
// itof_pipe: three-stage integer to IEEE-754 binary32 converter with a
// valid/ready handshake and an opaque tag carried alongside each operand.
//
//   S1  magnitude    : strip the sign, form the unsigned magnitude
//   S2  normalise    : locate the leading one and left-align it
//   S3  round / pack : round-to-nearest-even and assemble the result
//
// Build option: define ITOF_FLAGS_EN to add the out_inexact output, which
// flags conversions that lost precision. Results are identical either way.
//
// Flow control is a plain enable chain from out_ready back to in_ready
// with no skid buffer. A stage loads whenever its downstream slot is empty
// or is being emptied in the same cycle, so a full pipe that is draining
// keeps accepting one operand per cycle.

module itof_pipe #(
  parameter int IN_W  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_unsigned,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef ITOF_FLAGS_EN
  ,
  output logic             out_inexact
`endif
);

  // Width of the leading-one position. It covers 0 .. IN_W-1.
  localparam int PW = $clog2(IN_W);

  // Width of the bits below the leading one, padded with 24 zeros.
  // This keeps the 23 fraction bits and the guard bit addressable even
  // for narrow inputs.
  localparam int LW = IN_W + 23;

  // ---------------------------------------------------------------------
  // Stage valid bits and the enable chain
  // ---------------------------------------------------------------------
  logic v1;
  logic v2;
  logic en1;
  logic en2;
  logic en3;

  // en3 loads the output stage, en2 loads S2, en1 loads S1.
  assign en3      = ~out_valid | out_ready;
  assign en2      = ~v2 | en3;
  assign en1      = ~v1 | en2;
  assign in_ready = en1;

  // ---------------------------------------------------------------------
  // S1: sign and magnitude
  // ---------------------------------------------------------------------
  logic             sign_in;
  logic [IN_W-1:0]  mag_in;
  logic             sign1;
  logic [IN_W-1:0]  mag1;
  logic [TAG_W-1:0] tag1;

  // The most negative signed value negates to itself. As an unsigned
  // magnitude that is exactly 2^(IN_W-1), so no special case is needed.
  always_comb begin
    sign_in = ~in_unsigned & in_data[IN_W-1];
    mag_in  = sign_in ? -in_data : in_data;
  end

  // S1 data registers. They hold their value when no operand is loaded.
  always_ff @(posedge clk) begin
    if (en1 && in_valid) begin
      sign1 <= sign_in;
      mag1  <= mag_in;
      tag1  <= in_tag;
    end
  end

  // ---------------------------------------------------------------------
  // S2: leading-one detection and alignment
  // ---------------------------------------------------------------------
  logic [PW-1:0]    lead_pos;
  logic [PW-1:0]    shamt;
  logic [IN_W-1:0]  aligned;
  logic             sign2;
  logic             zero2;
  logic [PW-1:0]    p2;
  logic [IN_W-2:0]  below2;
  logic [TAG_W-1:0] tag2;

  // A priority scan from the LSB upwards leaves the highest set bit in
  // lead_pos. After alignment the top bit is set exactly when the
  // magnitude is non-zero, so it doubles as the zero detector. Only the
  // bits below the leading one are kept.
  always_comb begin
    lead_pos = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (mag1[i]) begin
        lead_pos = PW'(i);
      end
    end
    shamt   = PW'(IN_W - 1) - lead_pos;
    aligned = mag1 << shamt;
  end

  // S2 data registers. They hold their value when no operand is loaded.
  always_ff @(posedge clk) begin
    if (en2 && v1) begin
      sign2  <= sign1;
      zero2  <= ~aligned[IN_W-1];
      p2     <= lead_pos;
      below2 <= aligned[IN_W-2:0];
      tag2   <= tag1;
    end
  end

  // ---------------------------------------------------------------------
  // S3: round to nearest even and pack
  // ---------------------------------------------------------------------
  logic [LW-1:0] lower;
  logic [22:0]   frac_t;
  logic          guard_bit;
  logic          sticky_bit;
  logic          round_up;
  logic [23:0]   frac_sum;
  logic [7:0]    exp_res;
  logic [31:0]   result;
  logic          inexact_res;

  // When the leading one sits at bit 23 or lower, the guard and sticky
  // positions fall into the zero padding, so the result is exact. A carry
  // out of the fraction leaves the fraction at zero and bumps the
  // exponent. The exponent peaks at 127+64 for IN_W=64, so it never
  // overflows. Zero always packs as +0.0.
  always_comb begin
    lower       = {below2, 24'b0};
    frac_t      = lower[LW-1 -: 23];
    guard_bit   = lower[LW-24];
    sticky_bit  = |lower[LW-25:0];
    round_up    = guard_bit & (sticky_bit | frac_t[0]);
    frac_sum    = {1'b0, frac_t} + {23'b0, round_up};
    exp_res     = 8'd127 + {{(8-PW){1'b0}}, p2} + {7'b0, frac_sum[23]};
    inexact_res = ~zero2 & (guard_bit | sticky_bit);
    if (zero2) begin
      result = 32'h0000_0000;
    end else begin
      result = {sign2, exp_res, frac_sum[22:0]};
    end
  end

  // ---------------------------------------------------------------------
  // Valid bits for S1 and S2
  // ---------------------------------------------------------------------

  // Each valid bit follows its upstream valid bit whenever its stage
  // loads. A reset flushes everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (en1) begin
        v1 <= in_valid;
      end
      if (en2) begin
        v2 <= v1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output registers (S3)
  // ---------------------------------------------------------------------
  logic inexact_q;

  // The output payload changes only when a new result is loaded. It stays
  // frozen while the consumer stalls, and it reads 0 until the first
  // result appears.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= 32'h0000_0000;
      out_tag   <= '0;
      inexact_q <= 1'b0;
    end else if (en3) begin
      out_valid <= v2;
      if (v2) begin
        out_data  <= result;
        out_tag   <= tag2;
        inexact_q <= inexact_res;
      end
    end
  end

`ifdef ITOF_FLAGS_EN
  assign out_inexact = inexact_q;
`else
  // Without the flag port the inexact register has no consumer.
  // Synthesis removes it, and the results are unchanged.
  logic unused_inexact;
  assign unused_inexact = inexact_q;
`endif

endmodule
